risky_alu_master: RTL and testbench

Bus-side sequencer for the risky ALU: accepts one operation request (operand A, operand B, 4-bit mode `{F7 bit, F3}`) over a valid/ready handshake. It drives the shared tri-state `bus` and the 3-bit `ctrl` strobe through the ALU write/read protocol and returns the 32-bit result on a valid/ready response port. It sits between instruction execute logic and the ALU slave on the shared data bus. It caches the last mode written so back-to-back operations with the same mode skip the mode write.

---
 rtl/risky_alu_master.sv | 162 ++++++++++++++++
 tb/tb_risky_alu_master.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/risky_alu_master.sv
// risky_alu_master
// Bus-side sequencer for the risky ALU. It accepts one operation (A, B, mode)
// over a valid/ready request port and writes A, B and (unless cached) the mode
// to the ALU slave over the shared tri-state bus. It then reads the result
// back and presents it on a valid/ready response port.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  request present
//   req_ready  master can accept a request (high only in IDLE)
//   req_a      operand A
//   req_b      operand B
//   req_mode   ALU mode {F7 bit, F3}
//   rsp_valid  result available
//   rsp_ready  consumer takes the result
//   rsp_data   ALU result, held stable while rsp_valid is high
//   ctrl       bus command: 0 idle, 1 READ, 2 WRITE_A, 3 WRITE_B, 4 WRITE_MODE
//   bus        shared 32-bit tri-state data bus
module risky_alu_master (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [3:0]  req_mode,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [2:0]  ctrl,
    inout  wire  [31:0] bus
);

    localparam int unsigned BUS_W  = 32;
    localparam int unsigned MODE_W = 4;
    localparam int unsigned CTRL_W = 3;

    localparam logic [CTRL_W-1:0] CTRL_IDLE  = 3'd0;
    localparam logic [CTRL_W-1:0] CTRL_READ  = 3'd1;
    localparam logic [CTRL_W-1:0] CTRL_WR_A  = 3'd2;
    localparam logic [CTRL_W-1:0] CTRL_WR_B  = 3'd3;
    localparam logic [CTRL_W-1:0] CTRL_WR_M  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WA   = 3'd1,
        S_WB   = 3'd2,
        S_WM   = 3'd3,
        S_RD   = 3'd4,
        S_RSP  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [BUS_W-1:0]    a_q, b_q;
    logic [MODE_W-1:0]   mode_q;
    logic [MODE_W-1:0]   cache_mode_q;
    logic                cache_valid_q;
    logic                bus_oe_q;
    logic [BUS_W-1:0]    bus_data_c;

    logic                accept;
    logic                mode_hit;
    logic [CTRL_W-1:0]   ctrl_d;
    logic                bus_oe_d;
    logic                req_ready_d;
    logic                rsp_valid_d;

    assign accept   = (state_q == S_IDLE) && req_valid && req_ready;
    assign mode_hit = cache_valid_q && (cache_mode_q == mode_q);

    // Next state plus the registered output values that go with it
    always_comb begin
        state_d     = state_q;
        ctrl_d      = CTRL_IDLE;
        bus_oe_d    = 1'b0;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;

        case (state_q)
            S_IDLE:  if (accept) state_d = S_WA;
            S_WA:    state_d = S_WB;
            S_WB:    state_d = mode_hit ? S_RD : S_WM;
            S_WM:    state_d = S_RD;
            S_RD:    state_d = S_RSP;
            S_RSP:   if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_IDLE: req_ready_d = 1'b1;
            S_WA: begin
                ctrl_d   = CTRL_WR_A;
                bus_oe_d = 1'b1;
            end
            S_WB: begin
                ctrl_d   = CTRL_WR_B;
                bus_oe_d = 1'b1;
            end
            S_WM: begin
                ctrl_d   = CTRL_WR_M;
                bus_oe_d = 1'b1;
            end
            S_RD:    ctrl_d      = CTRL_READ;
            S_RSP:   rsp_valid_d = 1'b1;
            default: req_ready_d = 1'b0;
        endcase
    end

    // State, latched request, mode cache and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            a_q           <= '0;
            b_q           <= '0;
            mode_q        <= '0;
            cache_mode_q  <= '0;
            cache_valid_q <= 1'b0;
            bus_oe_q      <= 1'b0;
            ctrl          <= CTRL_IDLE;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
        end else begin
            state_q   <= state_d;
            ctrl      <= ctrl_d;
            bus_oe_q  <= bus_oe_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;

            if (accept) begin
                a_q    <= req_a;
                b_q    <= req_b;
                mode_q <= req_mode;
            end

            // Slave captures the mode at the end of WM, so the cache follows it
            if (state_q == S_WM) begin
                cache_mode_q  <= mode_q;
                cache_valid_q <= 1'b1;
            end

            if (state_q == S_RD) begin
                rsp_data <= bus;
            end
        end
    end

    // Write data comes only from the latched request, never from live req_* inputs
    always_comb begin
        bus_data_c = '0;
        case (state_q)
            S_WA:    bus_data_c = a_q;
            S_WB:    bus_data_c = b_q;
            S_WM:    bus_data_c = {{(BUS_W-MODE_W){1'b0}}, mode_q};
            default: bus_data_c = '0;
        endcase
    end

    assign bus = bus_oe_q ? bus_data_c : {BUS_W{1'bz}};

endmodule

// File: tb/tb_risky_alu_master.sv
// tb_risky_alu_master
// Directed plus randomized bench for risky_alu_master. A small ALU slave model
// answers READ cycles on the bus and drives zero on idle cycles. Expected
// command sequences, bus contents, latency and results come from a
// request-level reference model that tracks the last mode written.
module tb_risky_alu_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_mode;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [2:0]  ctrl;
    wire  [31:0] bus;

    int errors = 0;
    int checks = 0;

    // Reference model state: last mode the slave holds, invalidated by reset
    bit         ref_cache_v = 1'b0;
    logic [3:0] ref_cache_m = 4'd0;

    // Slave model registers; deliberately not reset, like the real slave
    logic [31:0] s_a = 32'd0;
    logic [31:0] s_b = 32'd0;
    logic [3:0]  s_mode = 4'd0;
    logic        tb_oe;
    logic [31:0] tb_drive;

    logic [3:0]  mode_tab [5];

    always #5 clk = ~clk;

    risky_alu_master dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_mode  (req_mode),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .ctrl      (ctrl),
        .bus       (bus)
    );

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] m);
        case (m)
            4'b0000: alu_ref = a + b;
            4'b1000: alu_ref = a - b;
            4'b0100: alu_ref = a ^ b;
            4'b0110: alu_ref = a | b;
            4'b0111: alu_ref = a & b;
            default: alu_ref = a + b;
        endcase
    endfunction

    // Slave: capture writes at the closing edge, answer READ combinationally
    always @(posedge clk) begin
        case (ctrl)
            3'd2: s_a <= bus;
            3'd3: s_b <= bus;
            3'd4: s_mode <= bus[3:0];
            default: ;
        endcase
    end

    assign tb_oe    = (ctrl == 3'd0) || (ctrl == 3'd1);
    assign tb_drive = (ctrl == 3'd1) ? alu_ref(s_a, s_b, s_mode) : 32'd0;
    assign bus      = tb_oe ? tb_drive : 32'bz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full operation; hold > 0 keeps rsp_ready low for that many RSP cycles
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] m, input int hold);
        logic [2:0]  exp_ctrl [4];
        logic [31:0] exp_bus  [4];
        logic [31:0] exp_res;
        logic [31:0] held;
        int          lat;
        int          got;
        bit          hit;

        hit     = ref_cache_v && (ref_cache_m == m);
        exp_res = alu_ref(a, b, m);
        exp_ctrl[0] = 3'd2; exp_bus[0] = a;
        exp_ctrl[1] = 3'd3; exp_bus[1] = b;
        if (hit) begin
            exp_ctrl[2] = 3'd1; exp_bus[2] = exp_res;
            exp_ctrl[3] = 3'd0; exp_bus[3] = 32'd0;
            lat = 4;
        end else begin
            exp_ctrl[2] = 3'd4; exp_bus[2] = {28'd0, m};
            exp_ctrl[3] = 3'd1; exp_bus[3] = exp_res;
            lat = 5;
        end
        ref_cache_v = 1'b1;
        ref_cache_m = m;

        check("idle_req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_mode  = m;
        rsp_ready = (hold == 0);

        got = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // Scramble request fields after acceptance; must not leak onto the bus
                req_a    = $urandom;
                req_b    = $urandom;
                req_mode = 4'($urandom);
            end
            req_valid = (k == 2) || (k == 3);
            if (rsp_valid) begin
                got = k;
                break;
            end
            if (k <= lat - 1) begin
                check($sformatf("ctrl_c%0d", k), 32'(ctrl), 32'(exp_ctrl[k-1]));
                check($sformatf("bus_c%0d", k), bus, exp_bus[k-1]);
                check($sformatf("busy_req_ready_c%0d", k), 32'(req_ready), 32'd0);
            end
        end
        req_valid = 1'b0;
        check("rsp_latency", 32'(got), 32'(lat));
        check("rsp_data", rsp_data, exp_res);
        check("rsp_ctrl", 32'(ctrl), 32'd0);
        check("rsp_bus_released", bus, 32'd0);
        check("rsp_req_ready", 32'(req_ready), 32'd0);

        if (hold > 0) begin
            held      = rsp_data;
            req_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
                check("hold_rsp_data", rsp_data, exp_res);
                check("hold_req_ready", 32'(req_ready), 32'd0);
                check("hold_ctrl", 32'(ctrl), 32'd0);
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
        end

        @(negedge clk);
        check("done_req_ready", 32'(req_ready), 32'd1);
        check("done_rsp_valid", 32'(rsp_valid), 32'd0);
        check("done_ctrl", 32'(ctrl), 32'd0);
        if (hold > 0) begin
            // A request offered while busy must not have been queued
            @(negedge clk);
            check("no_queued_op_ctrl", 32'(ctrl), 32'd0);
            check("no_queued_op_ready", 32'(req_ready), 32'd1);
        end
    endtask

    initial begin
        mode_tab[0] = 4'b0000;
        mode_tab[1] = 4'b1000;
        mode_tab[2] = 4'b0100;
        mode_tab[3] = 4'b0110;
        mode_tab[4] = 4'b0111;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_a     = 32'd0;
        req_b     = 32'd0;
        req_mode  = 4'd0;
        rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_ctrl", 32'(ctrl), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        check("reset_bus", bus, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed operations from the plan
        run_op(32'd5, 32'd3, 4'b0000, 0);
        run_op(32'd5, 32'd7, 4'b1000, 0);
        run_op(32'd10, 32'd4, 4'b1000, 0);
        run_op(32'd9, 32'd2, 4'b1000, 10);

        // Reset during WB abandons the op and invalidates the mode cache
        req_valid = 1'b1;
        req_a     = 32'h1234_5678;
        req_b     = 32'h0000_0011;
        req_mode  = 4'b1000;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_wb_ctrl", 32'(ctrl), 32'd3);
        rst_n = 1'b0;
        #1;
        check("midop_reset_ctrl", 32'(ctrl), 32'd0);
        check("midop_reset_req_ready", 32'(req_ready), 32'd1);
        check("midop_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midop_reset_rsp_data", rsp_data, 32'd0);
        check("midop_reset_bus", bus, 32'd0);
        ref_cache_v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_no_rsp", 32'(rsp_valid), 32'd0);
        run_op(32'd20, 32'd1, 4'b1000, 0);

        // Randomized operations, biased toward repeating the previous mode
        for (int n = 0; n < 12; n++) begin
            logic [3:0] m;
            if ($urandom_range(0, 2) == 0) m = ref_cache_m;
            else m = mode_tab[$urandom_range(0, 4)];
            run_op($urandom, $urandom, m, (n % 4 == 3) ? int'($urandom_range(1, 3)) : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
